// File: rtl/fadd_scheduler.sv
// fadd_scheduler: round-robin sharing of one fp adder among N_REQ requesters.
// Optional macro FADD_SCHED_ZERO_BYPASS_EN skips the adder for zero operands.
module fadd_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic [31:0]           add_res,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] tag;
    logic [ID_W-1:0] gnt;
    logic            found;
    logic [3:0]      cnt;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            hs;
    logic            bypass;
    logic [31:0]     byp_data;

    // first valid requester at or after ptr, wrapping
    always_comb begin
        int j;
        logic [ID_W-1:0] jj;
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            jj = ID_W'(j);
            if (!found && req_valid[jj]) begin
                found = 1'b1;
                gnt   = jj;
            end
        end
    end

    assign sel_a = req_a[{gnt, 5'd0} +: 32];
    assign sel_b = req_b[{gnt, 5'd0} +: 32];
    assign hs    = (state == IDLE) && found;

    // one-hot grant, only offered in IDLE and never during reset
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !rst) req_ready[gnt] = 1'b1;
    end

`ifdef FADD_SCHED_ZERO_BYPASS_EN
    // zero-magnitude operand: result is the other operand, no adder trip
    always_comb begin
        logic a_z;
        logic b_z;
        a_z    = (sel_a[30:0] == 31'd0);
        b_z    = (sel_b[30:0] == 31'd0);
        bypass = a_z || b_z;
        if (a_z && b_z)
            byp_data = {sel_a[31] & sel_b[31], 31'd0};
        else if (a_z)
            byp_data = sel_b;
        else
            byp_data = sel_a;
    end
`else
    assign bypass   = 1'b0;
    assign byp_data = '0;
`endif

    // next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (hs) state_nxt = bypass ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // operand capture, latency countdown and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            tag       <= '0;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else if (hs) begin
            tag <= gnt;
            if (gnt == ID_W'(N_REQ - 1)) ptr <= '0;
            else                         ptr <= gnt + 1'b1;
            if (bypass) begin
                resp_data <= byp_data;
                resp_id   <= gnt;
            end else begin
                add_a <= sel_a;
                add_b <= sel_b;
                cnt   <= 4'(LAT);
            end
        end else if (state == WAIT) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                resp_data <= add_res;
                resp_id   <= tag;
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fadd_scheduler.sv
// tb_fadd_scheduler: random requesters, cycle-level reference model,
// scoreboard queue checked by a response monitor.
module tb_fadd_scheduler;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [31:0]     add_res;
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    logic [31:0]     resp_data;
    logic            busy;

    always #5 clk = ~clk;

    fadd_scheduler #(.N_REQ(N), .ID_W(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    // adder stand-in: integer sum delayed LAT cycles
    logic [31:0] dly [0:15];
    always @(posedge clk) begin
        dly[0] <= add_a + add_b;
        for (int k = 1; k < 16; k++) dly[k] <= dly[k-1];
    end
    assign add_res = (LAT == 0) ? add_a + add_b : dly[LAT-1];

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;
    exp_t sb[$];

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    typedef enum {M_IDLE, M_WAIT, M_RESP} mst_t;
    mst_t        m_st;
    int          m_left;
    int          m_ptr;
    logic [31:0] m_add_a;
    logic [31:0] m_add_b;
    logic [N-1:0] hs_q;

    // reference model: expected grant, state outputs, pushes expectations
    always @(negedge clk or posedge rst) begin
        int g;
        logic [N-1:0] exp_rdy;
        logic [31:0] a;
        logic [31:0] b;
        exp_t e;
        if (rst) begin
            m_st = M_IDLE; m_ptr = 0; m_left = 0;
            m_add_a = 0; m_add_b = 0;
            hs_q = '0;
            sb.delete();
        end else begin
            exp_rdy = '0; g = -1; hs_q = '0;
            if (m_st == M_IDLE) begin
                g = pick(m_ptr, req_valid);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_st != M_IDLE));
            chk("resp_valid", 64'(resp_valid), 64'(m_st == M_RESP));
            chk("add_a", 64'(add_a), 64'(m_add_a));
            chk("add_b", 64'(add_b), 64'(m_add_b));
            case (m_st)
                M_IDLE: if (g >= 0) begin
                    hs_q[g] = 1'b1;
                    a = req_a[g*32 +: 32];
                    b = req_b[g*32 +: 32];
                    m_ptr = (g + 1) % N;
                    e.id = IDW'(g);
`ifdef FADD_SCHED_ZERO_BYPASS_EN
                    if (a[30:0] == 0 || b[30:0] == 0) begin
                        if (a[30:0] == 0 && b[30:0] == 0)
                            e.data = {a[31] & b[31], 31'd0};
                        else if (a[30:0] == 0) e.data = b;
                        else e.data = a;
                        m_st = M_RESP;
                    end else begin
                        e.data = a + b;
                        m_add_a = a; m_add_b = b;
                        m_st = M_WAIT; m_left = LAT + 1;
                    end
`else
                    e.data = a + b;
                    m_add_a = a; m_add_b = b;
                    m_st = M_WAIT; m_left = LAT + 1;
`endif
                    sb.push_back(e);
                end
                M_WAIT: begin
                    m_left--;
                    if (m_left == 0) m_st = M_RESP;
                end
                M_RESP: if (resp_ready) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    end

    // response monitor: compare whatever the DUT presents with the queue
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                chk("resp_id", 64'(resp_id), 64'(sb[0].id));
                chk("resp_data", 64'(resp_data), 64'(sb[0].data));
                if (resp_ready) void'(sb.pop_front());
            end
        end
    end

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        if ($urandom % 4 == 0) r = {r[31], 31'd0};
        return r;
    endfunction

    task automatic set_ops(input int i);
        req_a[i*32 +: 32] = rnd_op();
        req_b[i*32 +: 32] = rnd_op();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            if (m_st == M_IDLE && sb.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit hit;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        rst = 1'b0;

        // single op from requester 1
        req_a[32 +: 32] = 32'h3F80_0000;
        req_b[32 +: 32] = 32'h4000_0000;
        req_valid = 4'b0010;
        resp_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(posedge clk); #1;
            if (hs_q[1]) hit = 1'b1;
        end
        if (!hit) chk("first_grant_timeout", 64'd0, 64'd1);
        req_valid = '0;
        drain();

        // all four valid: round-robin order
        for (int i = 0; i < N; i++) set_ops(i);
        req_valid = '1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (hs_q[i]) set_ops(i);
        end
        drain();

        // random traffic with stalls and withdrawn requests
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (hs_q[i]) begin
                    req_valid[i] = 1'($urandom % 2);
                    set_ops(i);
                end else if (!req_valid[i]) begin
                    if ($urandom % 3 == 0) begin
                        req_valid[i] = 1'b1;
                        set_ops(i);
                    end
                end else if ($urandom % 16 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom % 4) != 0;
        end
        drain();

        // reset while waiting on the adder
        set_ops(2);
        req_valid = 4'b0100;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk); #1;
            if (m_st == M_WAIT) hit = 1'b1;
        end
        if (!hit) chk("wait_timeout", 64'd0, 64'd1);
        req_valid = '1;
        rst = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_add_a", 64'(add_a), 64'd0);
        chk("arst_add_b", 64'(add_b), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("grant_after_rst", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // requester 2 withdraws in IDLE, 3 picked up same cycle
        @(posedge clk); #1;
        set_ops(2); set_ops(3);
        req_valid = 4'b1100;
        #1;
        chk("pre_drop_ready", 64'(req_ready), 64'h4);
        req_valid = 4'b1000;
        #1;
        chk("drop_ready", 64'(req_ready), 64'h8);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
